// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller.
// It holds the PC, issues one fetch request at a time to the I-side memory, and
// buffers the returned instruction for decode. There is no branch prediction.
// After decode accepts a BRANCH, JAL or JALR, fetch stops until the branch unit
// returns the resolved next PC.
//
// Ports:
//   clk, rst_n         rising-edge clock; synchronous active-low reset
//   branch_dest_valid  1-cycle pulse carrying the resolved next PC (branch_dest)
//   if_req / if_addr   fetch request and address to I-memory
//   if_ack / if_inst   1-cycle acknowledge carrying the fetched instruction word
//   inst_valid / inst / inst_pc / inst_ready
//                      buffered instruction handshake to decode
//   waiting_branch     fetch is halted until a redirect arrives
//   br_stall_cycles    saturating count of cycles spent waiting for a redirect
module if_pc_ctrl #(
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  branch_dest_valid,
    input  logic [ADDR_WIDTH-1:0] branch_dest,
    output logic                  if_req,
    output logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_ack,
    input  logic [DATA_WIDTH-1:0] if_inst,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    output logic                  waiting_branch,
    output logic [31:0]           br_stall_cycles
);

    localparam int unsigned CNT_WIDTH = 32;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RST     = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_WAIT_BR = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  is_ctl;

    // The low two bits of the redirect target are dropped, because PCs are word aligned.
    logic unused_dest_lsbs;
    assign unused_dest_lsbs = ^branch_dest[1:0];

    // A control-flow instruction is in the buffer, so fetch must wait for the resolved PC.
    assign is_ctl = (inst[6:0] == OP_BRANCH) ||
                    (inst[6:0] == OP_JAL)    ||
                    (inst[6:0] == OP_JALR);

    // These outputs are decoded only from registered state.
    assign if_req         = (state == ST_FETCH);
    assign if_addr        = pc;
    assign inst_valid     = (state == ST_HOLD);
    assign waiting_branch = (state == ST_WAIT_BR);

    // This block is the fetch state machine, the PC, the instruction buffer and the stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_RST;
            pc              <= RESET_PC;
            inst            <= '0;
            inst_pc         <= '0;
            br_stall_cycles <= '0;
        end else begin
            case (state)
                // In this state an ack is a leftover from a request made before reset, so it is ignored.
                ST_RST: begin
                    state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (if_ack) begin
                        inst    <= if_inst;
                        inst_pc <= pc;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        if (is_ctl) begin
                            state <= ST_WAIT_BR;
                        end else begin
                            pc    <= pc + ADDR_WIDTH'(4);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_WAIT_BR: begin
                    if (branch_dest_valid) begin
                        pc    <= {branch_dest[ADDR_WIDTH-1:2], 2'b00};
                        state <= ST_FETCH;
                    end else if (br_stall_cycles != {CNT_WIDTH{1'b1}}) begin
                        br_stall_cycles <= br_stall_cycles + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Testbench for if_pc_ctrl with RESET_PC = 0x100.
// A table of vectors drives the reset, fetch, branch and spurious-input cases.
// Separate hand-written sequences cover backpressure, PC wraparound and reset during a branch wait.
module tb_if_pc_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_BEQ  = 32'h0020_8463;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_8067;

    logic          clk;
    logic          rst_n;
    logic          branch_dest_valid;
    logic [AW-1:0] branch_dest;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_inst;
    logic          inst_valid;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic          waiting_branch;
    logic [31:0]   br_stall_cycles;

    int n_checks;
    int n_pass;

    if_pc_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .branch_dest_valid (branch_dest_valid),
        .branch_dest       (branch_dest),
        .if_req            (if_req),
        .if_addr           (if_addr),
        .if_ack            (if_ack),
        .if_inst           (if_inst),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .inst_ready        (inst_ready),
        .waiting_branch    (waiting_branch),
        .br_stall_cycles   (br_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] idata;
        logic        ready;
        logic        bdv;
        logic [31:0] bdest;
        logic        e_req;
        logic        e_val;
        logic        e_wait;
        logic [31:0] e_addr;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // The bench drives inputs 1 time unit after the rising edge, so outputs are read between edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic a, input logic [31:0] d, input logic rd,
                         input logic bv, input logic [31:0] bd);
        rst_n = r; if_ack = a; if_inst = d; inst_ready = rd;
        branch_dest_valid = bv; branch_dest = bd;
    endtask

    function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d, input logic rd,
                                input logic bv, input logic [31:0] bd, input logic er,
                                input logic ev, input logic ew, input logic [31:0] ea,
                                input logic [31:0] ei, input logic [31:0] ep,
                                input logic [31:0] es);
        vec_t v;
        v.rst_n = r; v.ack = a; v.idata = d; v.ready = rd; v.bdv = bv; v.bdest = bd;
        v.e_req = er; v.e_val = ev; v.e_wait = ew; v.e_addr = ea; v.e_inst = ei;
        v.e_ipc = ep; v.e_stall = es;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);

        //            rst ack  idata        rdy  bdv  bdest         req val wt  addr          inst     ipc           stall
        vecs[0]  = mk(0,  1,  32'hDEAD_BEEF, 0,  0,  32'h0,        0,  0,  0,  RST_PC,       32'h0,   32'h0,        0);
        vecs[1]  = mk(0,  1,  32'hDEAD_BEEF, 0,  0,  32'h0,        0,  0,  0,  RST_PC,       32'h0,   32'h0,        0);
        // On the first edge out of reset, the ack is held high but the controller stays out of HOLD.
        vecs[2]  = mk(1,  1,  32'hDEAD_BEEF, 0,  0,  32'h0,        1,  0,  0,  RST_PC,       32'h0,   32'h0,        0);
        vecs[3]  = mk(1,  1,  I_ADDI,        0,  0,  32'h0,        0,  1,  0,  RST_PC,       I_ADDI,  RST_PC,       0);
        vecs[4]  = mk(1,  0,  32'h0,         1,  0,  32'h0,        1,  0,  0,  32'h104,      I_ADDI,  RST_PC,       0);
        // A spurious redirect in FETCH has no effect.
        vecs[5]  = mk(1,  1,  I_BEQ,         0,  1,  32'h500,      0,  1,  0,  32'h104,      I_BEQ,   32'h104,      0);
        // A spurious redirect in HOLD has no effect.
        vecs[6]  = mk(1,  0,  32'h0,         0,  1,  32'h600,      0,  1,  0,  32'h104,      I_BEQ,   32'h104,      0);
        vecs[7]  = mk(1,  0,  32'h0,         1,  0,  32'h0,        0,  0,  1,  32'h104,      I_BEQ,   32'h104,      0);
        vecs[8]  = mk(1,  0,  32'h0,         0,  0,  32'h0,        0,  0,  1,  32'h104,      I_BEQ,   32'h104,      1);
        vecs[9]  = mk(1,  0,  32'h0,         0,  0,  32'h0,        0,  0,  1,  32'h104,      I_BEQ,   32'h104,      2);
        vecs[10] = mk(1,  0,  32'h0,         0,  0,  32'h0,        0,  0,  1,  32'h104,      I_BEQ,   32'h104,      3);
        // A redirect to an unaligned target is aligned down to a word address.
        vecs[11] = mk(1,  0,  32'h0,         0,  1,  32'h203,      1,  0,  0,  32'h200,      I_BEQ,   32'h104,      3);
        vecs[12] = mk(1,  0,  32'h0,         0,  1,  32'h700,      1,  0,  0,  32'h200,      I_BEQ,   32'h104,      3);
        vecs[13] = mk(1,  1,  I_JAL,         0,  0,  32'h0,        0,  1,  0,  32'h200,      I_JAL,   32'h200,      3);
        // An ack outside FETCH is ignored.
        vecs[14] = mk(1,  1,  I_ADDI,        1,  0,  32'h0,        0,  0,  1,  32'h200,      I_JAL,   32'h200,      3);
        vecs[15] = mk(1,  0,  32'h0,         0,  1,  32'h300,      1,  0,  0,  32'h300,      I_JAL,   32'h200,      3);
        vecs[16] = mk(1,  1,  I_JALR,        0,  0,  32'h0,        0,  1,  0,  32'h300,      I_JALR,  32'h300,      3);
        vecs[17] = mk(1,  0,  32'h0,         0,  0,  32'h0,        0,  1,  0,  32'h300,      I_JALR,  32'h300,      3);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst_n, vecs[i].ack, vecs[i].idata, vecs[i].ready,
                  vecs[i].bdv, vecs[i].bdest);
            step();
            chk($sformatf("v%0d.if_req", i),          32'(if_req),         32'(vecs[i].e_req));
            chk($sformatf("v%0d.inst_valid", i),      32'(inst_valid),     32'(vecs[i].e_val));
            chk($sformatf("v%0d.waiting_branch", i),  32'(waiting_branch), 32'(vecs[i].e_wait));
            chk($sformatf("v%0d.if_addr", i),         if_addr,             vecs[i].e_addr);
            chk($sformatf("v%0d.inst", i),            inst,                vecs[i].e_inst);
            chk($sformatf("v%0d.inst_pc", i),         inst_pc,             vecs[i].e_ipc);
            chk($sformatf("v%0d.br_stall_cycles", i), br_stall_cycles,     vecs[i].e_stall);
        end

        // Backpressure: JALR is held in HOLD while decode stalls for 5 cycles.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp.inst", inst, I_JALR);
            chk("bp.inst_pc", inst_pc, 32'h300);
            chk("bp.if_req", 32'(if_req), 32'h0);
            chk("bp.inst_valid", 32'(inst_valid), 32'h1);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("bp.accept_wait", 32'(waiting_branch), 32'h1);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        step();
        chk("bp.redir_addr", if_addr, 32'h200);
        chk("bp.redir_req", 32'(if_req), 32'h1);
        chk("bp.stall_kept", br_stall_cycles, 32'd3);

        // Wrap: a redirect to 0xFFFF_FFFC, then a non-control instruction, wraps the PC to 0.
        drive(1'b1, 1'b1, I_BEQ, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step();
        chk("wrap.hi_addr", if_addr, 32'hFFFF_FFFC);
        drive(1'b1, 1'b1, I_ADDI, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap.inst_pc", inst_pc, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        chk("wrap.addr0", if_addr, 32'h0);
        chk("wrap.req", 32'(if_req), 32'h1);

        // Reset while waiting for a redirect.
        drive(1'b1, 1'b1, I_BEQ, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        chk("rstw.stall_pre", br_stall_cycles, 32'd5);
        chk("rstw.wait_pre", 32'(waiting_branch), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rstw.wait", 32'(waiting_branch), 32'h0);
        chk("rstw.stall", br_stall_cycles, 32'h0);
        chk("rstw.req", 32'(if_req), 32'h0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        chk("rstw.restart_req", 32'(if_req), 32'h1);
        chk("rstw.restart_addr", if_addr, RST_PC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
